// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard for a WIDTH-wide in-order issue group.
// Tracks load-use latency per register and a multi-cycle multiplier, and produces stall/flush controls.
module hazard_scoreboard #(
  parameter int WIDTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   valid,
  input  logic [5*WIDTH-1:0] rs,
  input  logic [5*WIDTH-1:0] rt,
  input  logic [5*WIDTH-1:0] wreg,
  input  logic [WIDTH-1:0]   regwrite,
  input  logic [WIDTH-1:0]   is_load,
  input  logic [WIDTH-1:0]   is_mult,
  input  logic [WIDTH-1:0]   reads_hilo,
  input  logic [WIDTH-1:0]   is_branch,
  input  logic [WIDTH-1:0]   taken,
  output logic [WIDTH-1:0]   stall_d,
  output logic [WIDTH-1:0]   flush_e,
  output logic               stall_f,
  output logic               mult_busy,
  output logic [31:0]        busy_mask
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT);
  localparam logic [3:0]    MUL_INIT  = 4'(MUL_LAT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mstate_t;

  mstate_t           state_r;
  logic [3:0]        mcnt_r;
  logic [CW-1:0]     cnt_r [32];

  logic [31:0]       busy_s;
  logic [31:0]       load_set_s;
  logic              mult_busy_s;
  logic              mult_go_s;
  logic [WIDTH-1:0]  haz_s;
  logic [WIDTH-1:0]  stall_s;
  logic [WIDTH-1:0]  killed_s;
  logic [WIDTH-1:0]  issue_s;

  assign mult_busy_s = (state_r == ST_BUSY);

  // Per-register busy flags; register 0 is hard-wired free.
  always_comb begin
    busy_s = 32'd0;
    for (int r = 0; r < 32; r++) begin
      busy_s[r] = (cnt_r[r] != CNT_ZERO);
    end
    busy_s[0] = 1'b0;
  end

  // Per-slot hazard: scoreboard RAW, intra-group RAW, and multiplier/HI-LO structural conflicts.
  always_comb begin
    logic [4:0] rs_v;
    logic [4:0] rt_v;
    logic [4:0] wj_v;
    logic       raw_v;
    logic       older_mult_v;
    haz_s = {WIDTH{1'b0}};
    rs_v = 5'd0;
    rt_v = 5'd0;
    wj_v = 5'd0;
    raw_v = 1'b0;
    older_mult_v = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      rs_v = rs[5*i +: 5];
      rt_v = rt[5*i +: 5];
      raw_v = busy_s[rs_v] | busy_s[rt_v];
      older_mult_v = 1'b0;
      for (int j = 0; j < i; j++) begin
        wj_v = wreg[5*j +: 5];
        raw_v = raw_v | (valid[j] & regwrite[j] & (wj_v != 5'd0) &
                         ((wj_v == rs_v) | (wj_v == rt_v)));
        older_mult_v = older_mult_v | (valid[j] & is_mult[j]);
      end
      haz_s[i] = valid[i] & (raw_v |
                 ((is_mult[i] | reads_hilo[i]) & (mult_busy_s | older_mult_v)));
    end
  end

  // In-order stall propagation; a taken branch that leaves decode kills every younger slot.
  always_comb begin
    logic kill_v;
    logic prev_v;
    stall_s  = {WIDTH{1'b0}};
    killed_s = {WIDTH{1'b0}};
    kill_v = 1'b0;
    prev_v = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      killed_s[i] = kill_v;
      stall_s[i]  = ~kill_v & (prev_v | (valid[i] & haz_s[i]));
      prev_v      = stall_s[i];
      kill_v      = kill_v | (valid[i] & is_branch[i] & taken[i] & ~stall_s[i]);
    end
  end

  assign issue_s = valid & ~stall_s & ~killed_s;

  // Registers armed by issuing loads this cycle; duplicates simply collapse onto one bit.
  always_comb begin
    load_set_s = 32'd0;
    for (int i = 0; i < WIDTH; i++) begin
      load_set_s[wreg[5*i +: 5]] = load_set_s[wreg[5*i +: 5]] |
                                   (issue_s[i] & is_load[i] & regwrite[i]);
    end
    load_set_s[0] = 1'b0;
  end

  assign mult_go_s = |(issue_s & is_mult);

  // Scoreboard counters and multiplier FSM; reset overrides any issue in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
      state_r <= ST_IDLE;
      mcnt_r  <= 4'd0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (load_set_s[r]) begin
          cnt_r[r] <= LOAD_INIT;
        end else if (cnt_r[r] != CNT_ZERO) begin
          cnt_r[r] <= cnt_r[r] - CNT_ONE;
        end else begin
          cnt_r[r] <= CNT_ZERO;
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (mult_go_s) begin
            state_r <= ST_BUSY;
            mcnt_r  <= MUL_INIT;
          end else begin
            state_r <= ST_IDLE;
            mcnt_r  <= 4'd0;
          end
        end
        ST_BUSY: begin
          if (mcnt_r == 4'd1) begin
            state_r <= ST_IDLE;
            mcnt_r  <= 4'd0;
          end else begin
            state_r <= ST_BUSY;
            mcnt_r  <= mcnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mcnt_r  <= 4'd0;
        end
      endcase
    end
  end

  assign stall_d   = stall_s;
  assign flush_e   = stall_s | killed_s | ~valid;
  assign stall_f   = |stall_s;
  assign mult_busy = mult_busy_s;
  assign busy_mask = busy_s;

  hazard_scoreboard_chk #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .stall_d   (stall_s),
    .flush_e   (flush_e),
    .stall_f   (stall_f),
    .mult_busy (mult_busy_s),
    .busy_mask (busy_s),
    .mcnt      (mcnt_r)
  );

endmodule

// Structural invariants of the scoreboard outputs and multiplier counter.
module hazard_scoreboard_chk #(
  parameter int WIDTH   = 2,
  parameter int MUL_LAT = 4
) (
  input logic             clk,
  input logic             reset,
  input logic [WIDTH-1:0] stall_d,
  input logic [WIDTH-1:0] flush_e,
  input logic             stall_f,
  input logic             mult_busy,
  input logic [31:0]      busy_mask,
  input logic [3:0]       mcnt
);

  localparam logic [3:0] MUL_MAX = 4'(MUL_LAT);

  a_zero_free: assert property (@(posedge clk) disable iff (reset) busy_mask[0] == 1'b0);
  a_stall_f:   assert property (@(posedge clk) disable iff (reset) stall_f == (|stall_d));
  a_flush_cov: assert property (@(posedge clk) disable iff (reset) (stall_d & ~flush_e) == {WIDTH{1'b0}});
  a_mcnt_busy: assert property (@(posedge clk) disable iff (reset) mult_busy == (mcnt != 4'd0));
  a_mcnt_max:  assert property (@(posedge clk) disable iff (reset) mcnt <= MUL_MAX);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios plus random bundles against a cycle-timestamp model.
module tb_hazard_scoreboard;

  localparam int W  = 2;
  localparam int LL = 1;
  localparam int ML = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [W-1:0]   valid, regwrite, is_load, is_mult, reads_hilo, is_branch, taken;
  logic [5*W-1:0] rs, rt, wreg;
  logic [W-1:0]   stall_d, flush_e;
  logic           stall_f, mult_busy;
  logic [31:0]    busy_mask;

  hazard_scoreboard #(.WIDTH(W), .LOAD_LAT(LL), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .valid(valid), .rs(rs), .rt(rt), .wreg(wreg),
    .regwrite(regwrite), .is_load(is_load), .is_mult(is_mult), .reads_hilo(reads_hilo),
    .is_branch(is_branch), .taken(taken), .stall_d(stall_d), .flush_e(flush_e),
    .stall_f(stall_f), .mult_busy(mult_busy), .busy_mask(busy_mask)
  );

  typedef struct {
    logic [W-1:0] stall;
    logic [W-1:0] flush;
    logic         sf;
    logic         mb;
    logic [31:0]  bm;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_at[32];   // register r is busy while cyc < ready_at[r]
  int mult_free = 0;  // multiplier busy while cyc < mult_free

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, req);
    end
  endtask

  task automatic clear_inputs();
    valid = '0; regwrite = '0; is_load = '0; is_mult = '0; reads_hilo = '0;
    is_branch = '0; taken = '0; rs = '0; rt = '0; wreg = '0;
  endtask

  task automatic set_slot(input int s, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                          input logic rw, input logic ld, input logic ml, input logic hl,
                          input logic br, input logic tk);
    valid[s] = 1'b1; wreg[5*s +: 5] = d; rs[5*s +: 5] = a; rt[5*s +: 5] = b;
    regwrite[s] = rw; is_load[s] = ld; is_mult[s] = ml; reads_hilo[s] = hl;
    is_branch[s] = br; taken[s] = tk;
  endtask

  // Reference model: compute this cycle's expectation, queue it, advance model, wait to negedge.
  task automatic tick();
    exp_t e;
    int mode;               // 0 issuing, 1 stalled from here on, 2 killed from here on
    logic hz, older_mult;
    logic [4:0] a, b, wj;
    int new_ready[32];
    int new_mult;
    for (int r = 0; r < 32; r++) new_ready[r] = ready_at[r];
    new_mult = mult_free;
    e.cyc = cyc;
    e.mb = (cyc < mult_free);
    for (int r = 0; r < 32; r++) e.bm[r] = (r != 0) && (cyc < ready_at[r]);
    e.stall = '0; e.flush = '0;
    mode = 0;
    for (int i = 0; i < W; i++) begin
      a = rs[5*i +: 5]; b = rt[5*i +: 5];
      hz = (a != 5'd0 && cyc < ready_at[a]) || (b != 5'd0 && cyc < ready_at[b]);
      older_mult = 1'b0;
      for (int j = 0; j < i; j++) begin
        wj = wreg[5*j +: 5];
        if (valid[j] && regwrite[j] && wj != 5'd0 && (wj == a || wj == b)) hz = 1'b1;
        if (valid[j] && is_mult[j]) older_mult = 1'b1;
      end
      if ((is_mult[i] || reads_hilo[i]) && (e.mb || older_mult)) hz = 1'b1;
      if (mode == 0 && valid[i] && hz) mode = 1;
      e.stall[i] = (mode == 1);
      e.flush[i] = (mode != 0) || !valid[i];
      if (mode == 0 && valid[i]) begin
        if (is_load[i] && regwrite[i] && wreg[5*i +: 5] != 5'd0) new_ready[wreg[5*i +: 5]] = cyc + 1 + LL;
        if (is_mult[i]) new_mult = cyc + 1 + ML;
        if (is_branch[i] && taken[i]) mode = 2;
      end
    end
    e.sf = |e.stall;
    if (reset) begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      mult_free = 0;
    end else begin
      q.push_back(e);
      for (int r = 0; r < 32; r++) ready_at[r] = new_ready[r];
      mult_free = new_mult;
    end
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
    clear_inputs();
  endtask

  // Monitor: pop one expectation per checked cycle and compare every output.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("sb_stall_d", 32'(stall_d), 32'(mon_e.stall));
      chk("sb_flush_e", 32'(flush_e), 32'(mon_e.flush));
      chk("sb_stall_f", 32'(stall_f), 32'(mon_e.sf));
      chk("sb_mult_busy", 32'(mult_busy), 32'(mon_e.mb));
      chk("sb_busy_mask", busy_mask, mon_e.bm);
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    clear_inputs();
    reset = 1'b1;
    tick(); adv();
    tick(); adv();
    reset = 1'b0;

    // Reset state
    tick();
    chk("rst_busy_mask", busy_mask, 32'd0);
    chk("rst_mult_busy", 32'(mult_busy), 32'd0);
    chk("rst_flush_e", 32'(flush_e), 32'd3);
    adv();

    // Load-use: lw $5 then add $6,$5,$1
    set_slot(0, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk("lu_issue", 32'(stall_d), 32'd0); adv();
    set_slot(0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk("lu_stall", 32'(stall_d), 32'd3); chk("lu_busy5", 32'(busy_mask[5]), 32'd1); adv();
    set_slot(0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk("lu_release", 32'(stall_d), 32'd0); adv();

    // Intra-bundle RAW
    set_slot(0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_slot(1, 5'd4, 5'd3, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk("ib_stall", 32'(stall_d), 32'd2); chk("ib_flush", 32'(flush_e), 32'd2); adv();
    set_slot(1, 5'd4, 5'd3, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk("ib_next", 32'(stall_d), 32'd0); adv();

    // Taken branch kills the younger load
    set_slot(0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    set_slot(1, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("br_flush", 32'(flush_e), 32'd2); chk("br_stall", 32'(stall_d), 32'd0);
    chk("br_stall_f", 32'(stall_f), 32'd0);
    adv();
    tick(); chk("br_busy7", 32'(busy_mask[7]), 32'd0); adv();

    // Multiplier occupancy, then mfhi
    set_slot(0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk("mul_issue", 32'(stall_d), 32'd0); adv();
    for (int k = 1; k <= 4; k++) begin
      set_slot(0, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); chk("mul_busy", 32'(mult_busy), 32'd1); chk("mfhi_stall", 32'(stall_d[0]), 32'd1); adv();
    end
    set_slot(0, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); chk("mul_done", 32'(mult_busy), 32'd0); chk("mfhi_issue", 32'(stall_d), 32'd0); adv();
    set_slot(0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_slot(1, 5'd0, 5'd3, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk("mul_pair", 32'(stall_d), 32'd2); adv();
    for (int k = 0; k < ML; k++) begin tick(); adv(); end

    // Register zero never busy
    set_slot(0, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_slot(1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk("r0_bundle", 32'(stall_d), 32'd0); adv();
    set_slot(0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk("r0_next", 32'(stall_d), 32'd0); chk("r0_mask", busy_mask, 32'd0); adv();

    // Reset in the second BUSY cycle, with a load trying to issue alongside
    set_slot(0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); adv();
    tick(); adv();
    reset = 1'b1;
    set_slot(0, 5'd12, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); adv();
    reset = 1'b0;
    tick(); chk("rb_mult_busy", 32'(mult_busy), 32'd0); chk("rb_mask", busy_mask, 32'd0); adv();

    // Random bundles
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int s = 0; s < W; s++) begin
        if ($urandom_range(0, 3) != 0) begin
          set_slot(s, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
                   1'($urandom_range(0, 9) < 1), 1'($urandom_range(0, 9) < 1),
                   1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 1)));
        end
      end
      tick(); adv();
    end
    reset = 1'b0;
    tick(); adv();

    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
